// File: rtl/keypad_scan.sv
// 4x4 matrix hex keypad scanner: column drive, frame-level debounce and
// two-digit entry register.
module keypad_scan #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [7:0] data
);
    // state   | meaning
    // IDLE    | no key accepted, waiting for a single-key frame
    // CONFIRM | candidate seen, counting identical frames before accepting
    // PRESSED | key accepted, counting non-matching frames before release
    typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED} state_t;

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       col_idx;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;

    logic [3:0] row_low;
    logic [2:0] col_hits;
    logic [1:0] row_sel;
    logic [1:0] base_hits;
    logic [3:0] base_code;
    logic [2:0] hit_sum;
    logic [1:0] frame_hits;
    logic [3:0] frame_code;
    logic       frame_end;
    logic       frame_single;

    state_t     state, state_next;
    logic [3:0] cand, cand_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic       accept, release_key;
    logic       valid_next, held_next;
    logic [3:0] code_next;
    logic [7:0] data_next;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt  <= '0;
            col_idx  <= 2'd0;
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                col_idx  <= col_idx + 2'd1;
                acc_hits <= frame_hits;
                acc_code <= frame_code;
            end
        end
    end

    assign col = ~(4'b0001 << col_idx);

    always_comb begin
        row_low  = ~row_sync;
        col_hits = 3'd0;
        row_sel  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                col_hits = col_hits + 3'd1;
                row_sel  = 2'(r);
            end
        end
    end

    // Column 0 starts a fresh frame; hit count saturates at 2 (MULTI).
    always_comb begin
        base_hits    = (col_idx == 2'd0) ? 2'd0 : acc_hits;
        base_code    = (col_idx == 2'd0) ? 4'd0 : acc_code;
        hit_sum      = {1'b0, base_hits} + col_hits;
        frame_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code   = (col_hits == 3'd1) ? key_map(row_sel, col_idx) : base_code;
        frame_end    = tick && (col_idx == 2'd3);
        frame_single = frame_end && (frame_hits == 2'd1);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            data      <= 8'h00;
        end else begin
            state     <= state_next;
            cand      <= cand_next;
            cnt       <= cnt_next;
            key_code  <= code_next;
            key_valid <= valid_next;
            key_held  <= held_next;
            data      <= data_next;
        end
    end

    always_comb begin
        state_next  = state;
        cand_next   = cand;
        cnt_next    = cnt;
        cnt_inc     = cnt + 4'd1;
        accept      = 1'b0;
        release_key = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_single) begin
                        cand_next = frame_code;
                        if (DB == 4'd1) begin
                            accept     = 1'b1;
                            state_next = PRESSED;
                            cnt_next   = 4'd0;
                        end else begin
                            state_next = CONFIRM;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                CONFIRM: begin
                    if (frame_single && frame_code == cand) begin
                        if (cnt_inc == DB) begin
                            accept     = 1'b1;
                            state_next = PRESSED;
                            cnt_next   = 4'd0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end
                end
                PRESSED: begin
                    // cnt doubles as the release counter while a key is held
                    if (frame_single && frame_code == key_code) begin
                        cnt_next = 4'd0;
                    end else if (cnt_inc == DB) begin
                        release_key = 1'b1;
                        state_next  = IDLE;
                        cnt_next    = 4'd0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        valid_next = accept;
        held_next  = key_held;
        code_next  = key_code;
        data_next  = data;
        if (accept) begin
            held_next = 1'b1;
            code_next = cand_next;
            data_next = {data[3:0], cand_next};
        end else if (release_key) begin
            held_next = 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed frame-level stimulus for keypad_scan, checked
// against a per-frame behavioural model of the debounce and entry rules.
module tb_keypad_scan;
    localparam int CLK_HZ  = 1000;
    localparam int SCAN_HZ = 250;
    localparam int DB      = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] data;

    logic [15:0] keys = 16'h0000;   // bit r*4+c set = key (r,c) pressed
    int n_checks = 0;
    int n_fail   = 0;

    int         m_phase;   // 0 waiting, 1 confirming, 2 held
    int         m_cnt, m_rel;
    logic [3:0] m_cand, m_code;
    logic       m_valid, m_held;
    logic [7:0] m_data;
    logic [3:0] hex_of [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scan #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk(clk), .clr(clr), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid),
        .key_held(key_held), .data(data)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_rel = 0;
        m_cand = 4'h0; m_code = 4'h0;
        m_valid = 1'b0; m_held = 1'b0; m_data = 8'h00;
    endtask

    task automatic model_accept();
        m_code  = m_cand;
        m_valid = 1'b1;
        m_held  = 1'b1;
        m_data  = {m_data[3:0], m_cand};
        m_phase = 2;
        m_rel   = 0;
    endtask

    task automatic model_frame(input logic [15:0] k);
        int         n;
        logic [3:0] kc;
        bit         single;
        n  = $countones(k);
        kc = 4'h0;
        for (int i = 0; i < 16; i++)
            if (k[i]) kc = hex_of[i];
        single  = (n == 1);
        m_valid = 1'b0;
        case (m_phase)
            0: if (single) begin
                m_cand = kc; m_cnt = 1; m_phase = 1;
                if (m_cnt == DB) model_accept();
            end
            1: if (single && kc == m_cand) begin
                m_cnt++;
                if (m_cnt == DB) model_accept();
            end else begin
                m_phase = 0; m_cnt = 0;
            end
            default: if (single && kc == m_code) begin
                m_rel = 0;
            end else begin
                m_rel++;
                if (m_rel == DB) begin
                    m_held = 1'b0; m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs(input logic [3:0] exp_col);
        check_val("col", {4'h0, col}, {4'h0, exp_col});
        check_val("key_valid", {7'h0, key_valid}, {7'h0, m_valid});
        check_val("key_held", {7'h0, key_held}, {7'h0, m_held});
        check_val("key_code", {4'h0, key_code}, {4'h0, m_code});
        check_val("data", data, m_data);
    endtask

    // One 16-clk frame aligned to column 0, keys stable throughout.
    task automatic run_frame(input logic [15:0] k);
        logic [3:0] one;
        logic [3:0] exp_col;
        keys = k;
        one  = 4'b0001;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) model_frame(k);
            else if (i == 1) m_valid = 1'b0;
            exp_col = ~(one << ((i / 4) % 4));
            check_outputs(exp_col);
        end
    endtask

    task automatic reset_mid(input int cycles);
        repeat (cycles) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        model_reset();
        check_outputs(4'b1110);
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        logic [15:0] k;
        int sel;
        model_reset();
        #1 clr = 1'b0;
        #11;
        check_outputs(4'b1110);
        @(negedge clk);
        clr = 1'b1;

        // scan sequence, then a reset partway through a frame
        repeat (2) run_frame(16'h0000);
        reset_mid(6);
        run_frame(16'h0000);

        // clean press of 6, long hold, release
        repeat (12) run_frame(16'h0040);
        check_val("press6_code", {4'h0, key_code}, 8'h06);
        check_val("press6_data", data, 8'h06);
        check_val("press6_held", {7'h0, key_held}, 8'h01);
        repeat (3) run_frame(16'h0000);
        check_val("release6_held", {7'h0, key_held}, 8'h00);

        // bounce on key 1
        repeat (4) begin
            run_frame(16'h0001);
            run_frame(16'h0000);
        end

        // two keys together, then only 5
        repeat (3) run_frame(16'h0021);
        repeat (3) run_frame(16'h0020);
        check_val("multi_code", {4'h0, key_code}, 8'h05);
        repeat (3) run_frame(16'h0000);

        // entry 1, A, then 0
        repeat (3) run_frame(16'h0001);
        repeat (3) run_frame(16'h0000);
        repeat (3) run_frame(16'h0008);
        repeat (3) run_frame(16'h0000);
        check_val("entry_1A", data, 8'h1A);
        repeat (3) run_frame(16'h2000);
        repeat (3) run_frame(16'h0000);
        check_val("entry_A0", data, 8'hA0);

        // one-frame glitch while 6 is held, then reset while held
        repeat (3) run_frame(16'h0040);
        run_frame(16'h0000);
        repeat (3) run_frame(16'h0040);
        check_val("glitch_held", {7'h0, key_held}, 8'h01);
        reset_mid(9);
        check_val("rst_held", {7'h0, key_held}, 8'h00);
        check_val("rst_data", data, 8'h00);

        // randomized frames biased toward repeats so keys get accepted
        k = 16'h0000;
        for (int f = 0; f < 80; f++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 6 || sel == 7)
                k = 16'h0000;
            else if (sel == 8)
                k = 16'(1) << $urandom_range(0, 15);
            else if (sel == 9)
                k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            run_frame(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix hex keypad scanner: the input-side counterpart of the seven-segment scan display path.
- Drives one active-low column at a time, samples the active-low rows and debounces over whole scan frames.
- Emits a one-cycle key event with a 4-bit hex code and assembles the last two keys into an 8-bit value.
- The 8-bit value feeds the counter's parallel `data` load input in place of the slide switches.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- SCAN_HZ, 1000, column step rate. DIV = CLK_HZ/SCAN_HZ (integer division); DIV must be >= 2.
- DEBOUNCE_SCANS, 4, number of consecutive identical frames required to accept a press or a release; range 1..15.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- row  in  4  keypad rows, active-low (external pull-ups), asynchronous to clk.
- col  out  4  column drive, active-low one-hot.
- key_code  out  4  hex code of the last accepted key.
- key_valid  out  1  one-clk pulse when a new key is accepted.
- key_held  out  1  high while the accepted key is considered pressed.
- data  out  8  two-digit entry register.

Behaviour:
- Reset (clr=0, asynchronous): col=4'b1110, key_code=0, key_valid=0, key_held=0, data=8'h00, state=IDLE. Divider, column index, frame accumulator and debounce counter all clear. Applies mid-scan and mid-debounce; the first tick after release samples column 0.
- Synchronizer: row passes through a 2-flop synchronizer before any use.
- Tick: the divider counts 0..DIV-1 and asserts tick for one clk when it reaches DIV-1, so there is one tick per DIV clks.
- On each tick:
  - Sample the synchronized row for the current column.
  - Then rotate col left: 1110 -> 1101 -> 1011 -> 0111 -> 1110. Each column is therefore driven for exactly DIV clks.
- Frame: 4 ticks (columns 0..3). The tick that samples column 3 closes the frame.
- Frame result is evaluated in the clk after the closing tick:
  - NONE if no row is low in any column.
  - KEY(code) if exactly one (row, col) is low in the whole frame.
  - MULTI if two or more are low. MULTI is treated as NONE for release counting and never produces an event.
- Code map, row r / col c, cols 0..3:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- FSM, evaluated once per frame:
  - IDLE: KEY(k) -> CONFIRM, cand=k, cnt=1. If DEBOUNCE_SCANS=1, accept immediately (same actions as CONFIRM reaching the count).
  - CONFIRM, on KEY(cand): cnt+1. When cnt reaches DEBOUNCE_SCANS: accept, go to PRESSED.
  - CONFIRM, on any other result: back to IDLE, cnt=0. A different single key does not restart as a new candidate in the same frame.
  - Accept actions, in one clk: key_code=cand, key_valid=1 for exactly one clk, key_held=1, data={data[3:0], cand}.
  - PRESSED, on KEY(key_code): stay, release cnt=0.
  - PRESSED, on any other result: release cnt+1. When it reaches DEBOUNCE_SCANS: key_held=0, go to IDLE.
  - A matching frame resets the release count.
- Repeat and hold rules:
  - No auto-repeat while a key is held.
  - key_code and data hold their values until the next accept.
- Latency: a press that is clean from the start of a frame produces key_valid in the clk after the closing tick of the DEBOUNCE_SCANS-th clean frame. Worst case adds one partial frame plus 2 synchronizer clks.

Test Plan:
- Bench settings: CLK_HZ=1000, SCAN_HZ=250 (DIV=4, frame=16 clks), DEBOUNCE_SCANS=2.
- Keypad model: row[r]=0 iff key(r,c) is pressed and col[c]=0.

1. Reset and scan sequence: assert clr=0 mid-frame -> all outputs take their reset values immediately. Release -> col steps 1110, 1101, 1011, 0111, 1110, each held 4 clks, with no key_valid.
2. Clean press: hold key r1c2 from a frame start -> key_valid single pulse at the clk after frame 2 closes, key_code=6, key_held=1, data=8'h06. Holding 10 frames gives no further pulses. Release -> key_held=0 after 2 NONE frames.
3. Bounce: press r0c0 on alternate frames -> no key_valid, key_held stays 0.
4. Multi-key: hold 1 (r0c0) and 5 (r1c1) -> no event. Release 1, keep 5 -> key_valid after 2 frames with key_code=5.
5. Entry: press/release 1, then A -> data=8'h1A. Press/release 0 -> data=8'hA0.
6. Glitch while held: holding 6, a single frame reads NONE -> key_held stays 1 and no new event. Reset asserted while in PRESSED -> key_held=0 and data=8'h00 immediately.
